mem_arbiter: RTL and testbench

- Shares one single-port word memory between the pipeline's instruction-fetch port and data port, so imem and dmem become one unified memory.
- Sits between the `pipe` core and a single `memory` instance.
- Issues at most one memory operation per cycle, returns read data to the correct requester and flags out-of-range accesses.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_resp_track.sv | 60 ++++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int STRB_W = 4;

  // Who owns the read response returned in the cycle after a grant.
  typedef enum logic [2:0] {
    NONE,
    RESP_IF,
    RESP_D,
    RESP_ERR_IF,
    RESP_ERR_D
  } owner_t;

  // An address is in range when every bit above the memory index is zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int idx_w);
    return (addr >> idx_w) == '0;
  endfunction

endpackage

// File: rtl/mem_arb_resp_track.sv
// Response owner register: remembers which port a granted read belongs to
// and steers the memory read data (or zero for an out-of-range read) to it.
module mem_arb_resp_track
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_rd,
  input  logic              d_rd,
  input  logic              oor,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata
);

  owner_t state_reg, state_next;

  // Owner register; reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= NONE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next owner comes only from this cycle's read grant.
  always_comb begin
    state_next = NONE;
    if (d_rd) begin
      state_next = oor ? RESP_ERR_D : RESP_D;
    end else if (if_rd) begin
      state_next = oor ? RESP_ERR_IF : RESP_IF;
    end
  end

  // Return data to the owner; error responses carry zero data.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    case (state_reg)
      RESP_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_read_data;
      end
      RESP_ERR_IF: if_rvalid = 1'b1;
      RESP_D: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_read_data;
      end
      RESP_ERR_D: d_rvalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port word memory.
// Data has priority; optional macro MEM_ARB_STARVE_GUARD_EN lets fetch win
// one contended cycle after STARVE_LIMIT consecutive data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_wdone,
  output logic              err,
  output logic              mem_read_ready,
  output logic              mem_write_ready,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [WORD_W-1:0] mem_write_data,
  output logic [STRB_W-1:0] mem_write_byte,
  input  logic [WORD_W-1:0] mem_read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              if_oor;
  logic              d_oor;
  logic              grant_open;
  logic              fetch_first;
  logic              rd_fire;
  logic              wr_fire;
  logic [ADDR_W-1:0] rd_addr_sel;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [WORD_W-1:0] wr_data_reg;
  logic [STRB_W-1:0] wr_strb_reg;

  assign if_oor = !addr_in_range(if_addr, IDX_W);
  assign d_oor  = !addr_in_range(d_addr, IDX_W);

  // Grants are purely combinational; nothing is granted in hold or reset.
  assign grant_open = !hold && !reset;
  assign d_gnt      = grant_open && d_req && !(fetch_first && if_req);
  assign if_gnt     = grant_open && if_req && !d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

  assign fetch_first = (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

  // Count consecutive data grants while fetch is kept waiting.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!if_req || if_gnt) begin
      starve_cnt_next = '0;
    end else if (d_gnt && (starve_cnt_reg < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Memory strobes only for in-range accesses; one grant per cycle means a
  // read and a write can never be issued together.
  assign rd_fire     = (if_gnt && !if_oor) || (d_gnt && !d_we && !d_oor);
  assign wr_fire     = d_gnt && d_we && !d_oor;
  assign rd_addr_sel = d_gnt ? d_addr : if_addr;

  assign mem_read_ready    = rd_fire;
  assign mem_write_ready   = wr_fire;
  assign mem_read_address  = rd_fire ? rd_addr_sel : rd_addr_reg;
  assign mem_write_address = wr_fire ? d_addr : wr_addr_reg;
  assign mem_write_data    = wr_fire ? d_wdata : wr_data_reg;
  assign mem_write_byte    = wr_fire ? d_wstrb : wr_strb_reg;

  assign err     = (if_gnt && if_oor) || (d_gnt && d_oor);
  assign d_wdone = d_gnt && d_we;

  // Memory-side address/data hold their last issued value between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_strb_reg <= '0;
    end else begin
      if (rd_fire) begin
        rd_addr_reg <= rd_addr_sel;
      end
      if (wr_fire) begin
        wr_addr_reg <= d_addr;
        wr_data_reg <= d_wdata;
        wr_strb_reg <= d_wstrb;
      end
    end
  end

  mem_arb_resp_track u_resp_track (
    .clk           (clk),
    .reset         (reset),
    .if_rd         (if_gnt),
    .d_rd          (d_gnt && !d_we),
    .oor           (d_gnt ? d_oor : if_oor),
    .mem_read_data (mem_read_data),
    .if_rvalid     (if_rvalid),
    .if_rdata      (if_rdata),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand sequences for reset,
// hold and fetch starvation, with a queue of expected read responses.
module tb_mem_arbiter;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_wdone;
  logic        err;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic [29:0] mem_read_address;
  logic [29:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .hold              (hold),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_gnt            (if_gnt),
    .if_rvalid         (if_rvalid),
    .if_rdata          (if_rdata),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_wstrb           (d_wstrb),
    .d_gnt             (d_gnt),
    .d_rvalid          (d_rvalid),
    .d_rdata           (d_rdata),
    .d_wdone           (d_wdone),
    .err               (err),
    .mem_read_ready    (mem_read_ready),
    .mem_write_ready   (mem_write_ready),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_byte    (mem_write_byte),
    .mem_read_data     (mem_read_data)
  );

  // Behavioural single-port memory with one-cycle registered read.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] mem_rd_q = 32'h0;
  logic        preload  = 1'b1;
  assign mem_read_data = mem_rd_q;

  always @(posedge clk) begin
    if (preload) begin
      mem[1] <= 32'h00100093;
      mem[2] <= 32'hDEADBEEF;
      mem[3] <= 32'hAABBCCDD;
      mem[5] <= 32'h00000013;
      mem[7] <= 32'h00000000;
    end else begin
      if (mem_write_ready) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_write_byte[b]) mem[mem_write_address[11:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
      end
      if (mem_read_ready) mem_rd_q <= mem[mem_read_address[11:0]];
    end
  end

  typedef struct {
    logic        hold;
    logic        ifr;
    logic [29:0] ifa;
    logic        dr;
    logic        dwe;
    logic [29:0] da;
    logic [31:0] dwd;
    logic [3:0]  dws;
    logic        eig;
    logic        edg;
    logic        eerr;
    logic        erd;
    logic        ewr;
    logic [29:0] eaddr;
    logic        rif;
    logic        rd;
    logic [31:0] rdat;
  } vec_t;

  typedef struct {
    logic        rif;
    logic        rd;
    logic [31:0] dat;
  } resp_t;

  resp_t resp_q[$];

  function automatic vec_t mk(input logic h, input logic ifr, input logic [29:0] ifa,
                              input logic dr, input logic dwe, input logic [29:0] da,
                              input logic [31:0] dwd, input logic [3:0] dws,
                              input logic eig, input logic edg, input logic eerr,
                              input logic erd, input logic ewr, input logic [29:0] eaddr,
                              input logic rif, input logic rd, input logic [31:0] rdat);
    vec_t v;
    v.hold = h;   v.ifr = ifr;  v.ifa = ifa;   v.dr = dr;   v.dwe = dwe;
    v.da = da;    v.dwd = dwd;  v.dws = dws;   v.eig = eig; v.edg = edg;
    v.eerr = eerr; v.erd = erd; v.ewr = ewr;   v.eaddr = eaddr;
    v.rif = rif;  v.rd = rd;    v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [167:0] all_out;
    all_out = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_wdone, err,
               mem_read_ready, mem_write_ready, mem_read_address, mem_write_address,
               mem_write_data, mem_write_byte};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h expected all zero", name, all_out);
    end
  endtask

  // Compare the response due this cycle against the oldest queued expectation.
  task automatic check_resp(input string tag);
    resp_t r;
    r = '{rif: 1'b0, rd: 1'b0, dat: 32'h0};
    if (resp_q.size() != 0) r = resp_q.pop_front();
    chk({tag, ".if_rvalid"}, {31'h0, if_rvalid}, {31'h0, r.rif});
    chk({tag, ".d_rvalid"}, {31'h0, d_rvalid}, {31'h0, r.rd});
    if (r.rif) chk({tag, ".if_rdata"}, if_rdata, r.dat);
    if (r.rd) chk({tag, ".d_rdata"}, d_rdata, r.dat);
  endtask

  task automatic drive(input vec_t v);
    hold    = v.hold;
    if_req  = v.ifr;
    if_addr = v.ifa;
    d_req   = v.dr;
    d_we    = v.dwe;
    d_addr  = v.da;
    d_wdata = v.dwd;
    d_wstrb = v.dws;
  endtask

  // One cycle: drive after the edge, check mid-cycle, queue the response.
  task automatic step(input vec_t v, input string tag);
    resp_t r;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_resp(tag);
    chk({tag, ".if_gnt"}, {31'h0, if_gnt}, {31'h0, v.eig});
    chk({tag, ".d_gnt"}, {31'h0, d_gnt}, {31'h0, v.edg});
    chk({tag, ".err"}, {31'h0, err}, {31'h0, v.eerr});
    chk({tag, ".mem_read_ready"}, {31'h0, mem_read_ready}, {31'h0, v.erd});
    chk({tag, ".mem_write_ready"}, {31'h0, mem_write_ready}, {31'h0, v.ewr});
    chk({tag, ".d_wdone"}, {31'h0, d_wdone}, {31'h0, v.edg & v.dwe});
    if (v.erd) chk({tag, ".mem_read_address"}, {2'b0, mem_read_address}, {2'b0, v.eaddr});
    if (v.ewr) begin
      chk({tag, ".mem_write_address"}, {2'b0, mem_write_address}, {2'b0, v.eaddr});
      chk({tag, ".mem_write_data"}, mem_write_data, v.dwd);
      chk({tag, ".mem_write_byte"}, {28'h0, mem_write_byte}, {28'h0, v.dws});
    end
    r.rif = v.rif;
    r.rd  = v.rd;
    r.dat = v.rdat;
    resp_q.push_back(r);
    $display("step %-10s if_gnt=%0b d_gnt=%0b err=%0b rd=%0b wr=%0b if_rvalid=%0b d_rvalid=%0b",
             tag, if_gnt, d_gnt, err, mem_read_ready, mem_write_ready, if_rvalid, d_rvalid);
  endtask

  vec_t vecs[15];

  initial begin
    vec_t v;
    logic fetch_turn;

    //         hold ifr ifa   dr dwe da    dwd            dws      eig edg err rd wr eaddr rif rd rdat
    vecs[0]  = mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0,    0, 0, 0, 0, 0, 0,    0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 5,    0, 0, 0,    32'h0,         4'h0,    1, 0, 0, 1, 0, 5,    1, 0, 32'h00000013);
    vecs[2]  = mk(0, 1, 1,    1, 0, 2,    32'h0,         4'h0,    0, 1, 0, 1, 0, 2,    0, 1, 32'hDEADBEEF);
    vecs[3]  = mk(0, 1, 1,    0, 0, 0,    32'h0,         4'h0,    1, 0, 0, 1, 0, 1,    1, 0, 32'h00100093);
    vecs[4]  = mk(0, 0, 0,    1, 1, 3,    32'h11223344,  4'b0011, 0, 1, 0, 0, 1, 3,    0, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0,    1, 0, 3,    32'h0,         4'h0,    0, 1, 0, 1, 0, 3,    0, 1, 32'hAABB3344);
    vecs[6]  = mk(0, 0, 0,    1, 0, 4096, 32'h0,         4'h0,    0, 1, 1, 0, 0, 0,    0, 1, 32'h0);
    vecs[7]  = mk(0, 1, 4097, 0, 0, 0,    32'h0,         4'h0,    1, 0, 1, 0, 0, 0,    1, 0, 32'h0);
    vecs[8]  = mk(0, 0, 0,    1, 1, 4099, 32'hFFFFFFFF,  4'hF,    0, 1, 1, 0, 0, 0,    0, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0,    1, 0, 3,    32'h0,         4'h0,    0, 1, 0, 1, 0, 3,    0, 1, 32'hAABB3344);
    vecs[10] = mk(1, 1, 5,    1, 0, 2,    32'h0,         4'h0,    0, 0, 0, 0, 0, 0,    0, 0, 32'h0);
    vecs[11] = mk(0, 1, 5,    1, 1, 7,    32'h00000055,  4'hF,    0, 1, 0, 0, 1, 7,    0, 0, 32'h0);
    vecs[12] = mk(0, 1, 5,    1, 0, 7,    32'h0,         4'h0,    0, 1, 0, 1, 0, 7,    0, 1, 32'h00000055);
    vecs[13] = mk(0, 1, 5,    0, 0, 0,    32'h0,         4'h0,    1, 0, 0, 1, 0, 5,    1, 0, 32'h00000013);
    vecs[14] = mk(0, 0, 0,    0, 0, 0,    32'h0,         4'h0,    0, 0, 0, 0, 0, 0,    0, 0, 32'h0);

    // Reset with both requests pending: every output must be zero.
    reset = 1'b1;
    drive(vecs[0]);
    if_req = 1'b1;
    d_req  = 1'b1;
    @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk);
    #1;
    reset   = 1'b0;
    preload = 1'b0;
    drive(vecs[0]);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Read granted, then reset lands before the response is sampled.
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 1, 0, 2, 32'h0, 4'h0, 0, 1, 0, 1, 0, 2, 0, 1, 32'hDEADBEEF));
    @(negedge clk);
    check_resp("rst_grant");
    chk("rst_grant.d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("rst_grant.mem_read_ready", {31'h0, mem_read_ready}, 32'h1);
    $display("step rst_grant  d_gnt=%0b", d_gnt);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    chk_zero("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero($sformatf("post_reset%0d", i));
      $display("step post_rst%0d d_rvalid=%0b if_rvalid=%0b", i, d_rvalid, if_rvalid);
    end

    // Hold with both requests pending: no grants at all.
    for (int i = 0; i < 3; i++) begin
      step(vecs[10], $sformatf("hold%0d", i));
    end

    // Continuous contention: data read of word 2 against fetch of word 5.
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      fetch_turn = ((k % 5) == 4);
`else
      fetch_turn = 1'b0;
`endif
      v = mk(0, 1, 5, 1, 0, 2, 32'h0, 4'h0, fetch_turn, !fetch_turn, 0, 1, 0,
             fetch_turn ? 30'd5 : 30'd2, fetch_turn, !fetch_turn,
             fetch_turn ? 32'h00000013 : 32'hDEADBEEF);
      step(v, $sformatf("starve%0d", k));
    end
    step(vecs[0], "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
